// File: rtl/dsp_issue_ctrl.sv
// Issue/interlock controller between fetch and DSPDecode: register scoreboard,
// RAW/WAW stall, flow-control issue hold and taken-branch fetch flush.
module dsp_issue_ctrl #(
   parameter int unsigned WB_LAT        = 3,
   parameter int unsigned LD_LAT        = 4,
   parameter int unsigned CNT_W         = 3,
   parameter int unsigned STALL_CNT_W   = 16,
   parameter int unsigned REG_ADDR_LEN  = 5,
   parameter int unsigned MEM_MODE_LEN  = 3,
   parameter int unsigned FLOW_MODE_LEN = 3,
   parameter logic [MEM_MODE_LEN-1:0]  MEM_LD     = MEM_MODE_LEN'(1),
   parameter logic [MEM_MODE_LEN-1:0]  MEM_LD_IMM = MEM_MODE_LEN'(2),
   parameter logic [FLOW_MODE_LEN-1:0] FLOW_NONE  = FLOW_MODE_LEN'(0)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_valid,
   input  logic                     dec_src1_use,
   input  logic                     dec_src2_use,
   input  logic                     dec_src3_use,
   input  logic [REG_ADDR_LEN-1:0]  dec_reg_addr1,
   input  logic [REG_ADDR_LEN-1:0]  dec_reg_addr2,
   input  logic [REG_ADDR_LEN-1:0]  dec_reg_addr3,
   input  logic [REG_ADDR_LEN-1:0]  dec_reg_dest,
   input  logic                     dec_write_back_en,
   input  logic [MEM_MODE_LEN-1:0]  dec_mem_mode,
   input  logic [FLOW_MODE_LEN-1:0] dec_flow_mode,
   input  logic                     pipe_hold,
   input  logic                     br_resolve_valid,
   input  logic                     br_taken,
   output logic                     issue_valid,
   output logic                     dec_stall,
   output logic                     fetch_flush,
   output logic [STALL_CNT_W-1:0]   stall_count
);

   localparam int unsigned NUM_REGS = 32'(1) << REG_ADDR_LEN;

   typedef enum logic {RUN, BR_WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt [NUM_REGS];
   logic [CNT_W-1:0] new_cnt;
   logic             is_load;
   logic             src_hz;
   logic             waw_hz;
   logic             hz;

   // The issue cycle is the first of the latency cycles, so a consumer
   // presented right behind the producer issues exactly LAT cycles later.
   always_comb begin
      is_load = (dec_mem_mode == MEM_LD) || (dec_mem_mode == MEM_LD_IMM);
      new_cnt = is_load ? CNT_W'(LD_LAT - 1) : CNT_W'(WB_LAT - 1);
      src_hz  = (dec_src1_use && (cnt[dec_reg_addr1] != '0)) ||
                (dec_src2_use && (cnt[dec_reg_addr2] != '0)) ||
                (dec_src3_use && (cnt[dec_reg_addr3] != '0));
      waw_hz  = dec_write_back_en && (cnt[dec_reg_dest] > new_cnt);
      hz      = dec_valid && (src_hz || waw_hz);
      issue_valid = !rst && dec_valid && !hz && !pipe_hold && (state == RUN);
      dec_stall   = !rst && dec_valid && !issue_valid;
   end

   // Scoreboard: frozen under pipe_hold, new writer overrides the decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      end else if (!pipe_hold) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (issue_valid && dec_write_back_en && (dec_reg_dest == REG_ADDR_LEN'(i)))
               cnt[i] <= new_cnt;
            else if (cnt[i] != '0)
               cnt[i] <= cnt[i] - CNT_W'(1);
         end
      end
   end

   // Flow-control FSM; resolution is accepted regardless of pipe_hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         fetch_flush <= 1'b0;
      end else begin
         fetch_flush <= 1'b0;
         case (state)
            RUN: begin
               if (issue_valid && (dec_flow_mode != FLOW_NONE)) state <= BR_WAIT;
            end
            BR_WAIT: begin
               if (br_resolve_valid) begin
                  state       <= RUN;
                  fetch_flush <= br_taken;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Saturating stall performance counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_count <= '0;
      else if (dec_stall && (stall_count != '1))
         stall_count <= stall_count + STALL_CNT_W'(1);
   end

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Self-checking bench for dsp_issue_ctrl: per-cycle vectors with expected
// issue/stall/flush pushed to a scoreboard queue, plus a stall_count model.
module tb_dsp_issue_ctrl;

   localparam int unsigned SCW = 5;
   localparam logic [2:0] M_LD = 3'd1, M_LDI = 3'd2, M_ST = 3'd3;
   localparam logic [2:0] F_BEQ = 3'd1, F_BNEZ = 3'd2, F_JMP = 3'd3;

   logic clk = 1'b0;
   logic rst;
   logic dec_valid, dec_src1_use, dec_src2_use, dec_src3_use;
   logic [4:0] dec_reg_addr1, dec_reg_addr2, dec_reg_addr3, dec_reg_dest;
   logic dec_write_back_en;
   logic [2:0] dec_mem_mode, dec_flow_mode;
   logic pipe_hold, br_resolve_valid, br_taken;
   logic issue_valid, dec_stall, fetch_flush;
   logic [SCW-1:0] stall_count;

   typedef struct {
      logic v, u1, u2, u3;
      logic [4:0] a1, a2, a3, d;
      logic wb;
      logic [2:0] mem, flow;
      logic hold, brv, brt;
      logic eiv, est, eff;
   } vec_t;

   typedef struct {
      logic iv, st, ff;
   } exp_t;

   exp_t exp_q[$];
   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   exp_sc = 0;

   dsp_issue_ctrl #(.STALL_CNT_W(SCW)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_src1_use(dec_src1_use),
      .dec_src2_use(dec_src2_use), .dec_src3_use(dec_src3_use),
      .dec_reg_addr1(dec_reg_addr1), .dec_reg_addr2(dec_reg_addr2),
      .dec_reg_addr3(dec_reg_addr3), .dec_reg_dest(dec_reg_dest),
      .dec_write_back_en(dec_write_back_en), .dec_mem_mode(dec_mem_mode),
      .dec_flow_mode(dec_flow_mode), .pipe_hold(pipe_hold),
      .br_resolve_valid(br_resolve_valid), .br_taken(br_taken),
      .issue_valid(issue_valid), .dec_stall(dec_stall),
      .fetch_flush(fetch_flush), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t vec(input logic v, u1, u2, u3,
                                input logic [4:0] a1, a2, a3, d,
                                input logic wb, input logic [2:0] mem, flow,
                                input logic hold, brv, brt, eiv, est, eff);
      vec_t x;
      x.v = v; x.u1 = u1; x.u2 = u2; x.u3 = u3;
      x.a1 = a1; x.a2 = a2; x.a3 = a3; x.d = d;
      x.wb = wb; x.mem = mem; x.flow = flow;
      x.hold = hold; x.brv = brv; x.brt = brt;
      x.eiv = eiv; x.est = est; x.eff = eff;
      return x;
   endfunction

   function automatic vec_t alu(input logic [4:0] d, a1, a2, input logic eiv, est);
      return vec(1, 1, 1, 0, a1, a2, 5'd0, d, 1, 3'd0, 3'd0, 0, 0, 0, eiv, est, 0);
   endfunction

   function automatic vec_t idle(input logic eff);
      return vec(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, eff);
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   // Drive one vector now, then sample outputs 2ns later (well before posedge).
   task automatic drive_chk(input vec_t x, input string nm);
      exp_t e;
      dec_valid = x.v; dec_src1_use = x.u1; dec_src2_use = x.u2; dec_src3_use = x.u3;
      dec_reg_addr1 = x.a1; dec_reg_addr2 = x.a2; dec_reg_addr3 = x.a3;
      dec_reg_dest = x.d; dec_write_back_en = x.wb;
      dec_mem_mode = x.mem; dec_flow_mode = x.flow;
      pipe_hold = x.hold; br_resolve_valid = x.brv; br_taken = x.brt;
      exp_q.push_back('{x.eiv, x.est, x.eff});
      #2;
      e = exp_q.pop_front();
      chk({nm, ".issue_valid"}, int'(issue_valid), int'(e.iv));
      chk({nm, ".dec_stall"},   int'(dec_stall),   int'(e.st));
      chk({nm, ".fetch_flush"}, int'(fetch_flush), int'(e.ff));
      chk({nm, ".stall_count"}, int'(stall_count), exp_sc);
      if (e.st && exp_sc < (2**SCW - 1)) exp_sc++;
   endtask

   task automatic run(input vec_t x, input string nm);
      @(negedge clk);
      drive_chk(x, nm);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".issue_valid"}, int'(issue_valid), 0);
      chk({nm, ".dec_stall"},   int'(dec_stall),   0);
      chk({nm, ".fetch_flush"}, int'(fetch_flush), 0);
      chk({nm, ".stall_count"}, int'(stall_count), 0);
   endtask

   initial begin
      vec_t x;
      rst = 1'b1;
      dec_valid = 0; dec_src1_use = 0; dec_src2_use = 0; dec_src3_use = 0;
      dec_reg_addr1 = 0; dec_reg_addr2 = 0; dec_reg_addr3 = 0; dec_reg_dest = 0;
      dec_write_back_en = 0; dec_mem_mode = 0; dec_flow_mode = 0;
      pipe_hold = 0; br_resolve_valid = 0; br_taken = 0;
      @(negedge clk);
      #2 chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // RAW on ALU, load latency, unused source, WAW, src3, store without writeback
      tbl.push_back(alu(5'd3, 5'd1, 5'd2, 1, 0));
      tbl.push_back(alu(5'd4, 5'd3, 5'd1, 0, 1));
      tbl.push_back(alu(5'd4, 5'd3, 5'd1, 0, 1));
      tbl.push_back(alu(5'd4, 5'd3, 5'd1, 1, 0));
      tbl.push_back(idle(0));
      tbl.push_back(vec(1, 1, 0, 0, 5'd1, 5'd0, 5'd0, 5'd5, 1, M_LD, 3'd0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(alu(5'd6, 5'd5, 5'd2, 0, 1));
      tbl.push_back(alu(5'd6, 5'd5, 5'd2, 0, 1));
      tbl.push_back(alu(5'd6, 5'd5, 5'd2, 0, 1));
      tbl.push_back(alu(5'd6, 5'd5, 5'd2, 1, 0));
      tbl.push_back(vec(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd5, 1, M_LDI, 3'd0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vec(1, 0, 1, 0, 5'd5, 5'd2, 5'd5, 5'd8, 1, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(idle(0));
      tbl.push_back(vec(1, 1, 0, 0, 5'd1, 5'd0, 5'd0, 5'd9, 1, M_LD, 3'd0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(alu(5'd9, 5'd1, 5'd2, 0, 1));
      tbl.push_back(alu(5'd9, 5'd1, 5'd2, 1, 0));
      tbl.push_back(alu(5'd31, 5'd1, 5'd2, 1, 0));
      tbl.push_back(vec(1, 1, 1, 1, 5'd1, 5'd2, 5'd31, 5'd10, 1, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(vec(1, 1, 1, 1, 5'd1, 5'd2, 5'd31, 5'd10, 1, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(vec(1, 1, 1, 1, 5'd1, 5'd2, 5'd31, 5'd10, 1, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vec(1, 1, 1, 0, 5'd1, 5'd2, 5'd0, 5'd11, 0, M_ST, 3'd0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(alu(5'd12, 5'd11, 5'd1, 1, 0));
      for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("tbl[%0d]", i));
      run(idle(0), "tbl_end");
      chk("tbl_end.stall_count_const", int'(stall_count), 8);

      // Taken BEQ resolved four cycles after issue
      run(vec(1, 1, 1, 0, 5'd1, 5'd2, 5'd0, 5'd0, 0, 3'd0, F_BEQ, 0, 0, 0, 1, 0, 0), "beq");
      for (int k = 0; k < 4; k++) begin
         x = alu(5'd12, 5'd1, 5'd2, 0, 1);
         x.brv = (k == 3); x.brt = (k == 3);
         run(x, $sformatf("beq_wait[%0d]", k));
      end
      x = alu(5'd12, 5'd1, 5'd2, 1, 0); x.eff = 1;
      run(x, "beq_flush");
      run(idle(0), "beq_after");

      // Not-taken BNEZ, and resolve while in RUN is ignored
      run(vec(1, 1, 0, 0, 5'd1, 5'd0, 5'd0, 5'd0, 0, 3'd0, F_BNEZ, 0, 0, 0, 1, 0, 0), "bnez");
      run(idle(0), "bnez_wait");
      x = idle(0); x.brv = 1; x.brt = 0;
      run(x, "bnez_res");
      run(alu(5'd13, 5'd1, 5'd2, 1, 0), "bnez_run");
      x = idle(0); x.brv = 1; x.brt = 1;
      run(x, "run_res");
      run(idle(0), "run_res_noflush");

      // Jump resolved while pipe_hold is high
      run(vec(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 3'd0, F_JMP, 0, 0, 0, 1, 0, 0), "jmp");
      x = idle(0); x.hold = 1; x.brv = 1; x.brt = 1;
      run(x, "jmp_hold_res");
      x = alu(5'd13, 5'd1, 5'd2, 1, 0); x.eff = 1;
      run(x, "jmp_flush");

      // pipe_hold freezes the scoreboard with cnt[r3] pending
      run(alu(5'd3, 5'd1, 5'd2, 1, 0), "hold_prod");
      for (int k = 0; k < 5; k++) begin
         x = alu(5'd14, 5'd3, 5'd1, 0, 1); x.hold = 1;
         run(x, $sformatf("hold[%0d]", k));
      end
      run(alu(5'd14, 5'd3, 5'd1, 0, 1), "hold_drop0");
      run(alu(5'd14, 5'd3, 5'd1, 0, 1), "hold_drop1");
      run(alu(5'd14, 5'd3, 5'd1, 1, 0), "hold_issue");

      // Reset in BR_WAIT with r7 pending
      run(vec(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd7, 1, M_LD, F_BEQ, 0, 0, 0, 1, 0, 0), "ldbr");
      run(alu(5'd15, 5'd7, 5'd1, 0, 1), "ldbr_wait");
      #1 rst = 1'b1;
      #1 chk_zero("rst_async");
      exp_sc = 0;
      @(negedge clk);
      #2 chk_zero("rst_held");
      @(negedge clk);
      rst = 1'b0;
      drive_chk(alu(5'd15, 5'd7, 5'd1, 1, 0), "rst_release");

      // Saturation of stall_count
      for (int k = 0; k < 35; k++) begin
         x = alu(5'd16, 5'd1, 5'd2, 0, 1); x.hold = 1;
         run(x, $sformatf("sat[%0d]", k));
      end
      run(idle(0), "sat_end");
      chk("sat_end.stall_count_const", int'(stall_count), 31);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
